// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, two writeback ports, issue/scoreboard signals.
// The master drives addresses, writes and issue; the slave (register file) returns data and status.
interface regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            rdy1;
  logic            rdy2;
  logic            we0;
  logic [AW-1:0]   wa0;
  logic [XLEN-1:0] wd0;
  logic            we1;
  logic [AW-1:0]   wa1;
  logic [XLEN-1:0] wd1;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  logic            iss_waw;
  logic [AW:0]     busy_cnt;

  modport master (
    output a1, a2, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_rd,
    input  rd1, rd2, rdy1, rdy2, iss_waw, busy_cnt
  );

  modport slave (
    input  a1, a2, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_rd,
    output rd1, rd2, rdy1, rdy2, iss_waw, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// 2R/2W integer register file with write-to-read bypass and an in-flight-write scoreboard.
// Optional RF_RESET_EN: reset also clears storage (flop-based); otherwise storage is reset-free.
module regfile_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic        clk,
  input  logic        reset,
  regfile_sb_if.slave bus
);

  logic [XLEN-1:0]  r_rf [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;

  logic             w_wr0;
  logic             w_wr1;
  logic             w_iss;
  logic [NREGS-1:0] w_busy_next;
  logic             w_inc;
  logic             w_dec0;
  logic             w_dec1;
  logic             w_hit1;
  logic             w_hit2;
  logic             w_hit_iss;

  // Effective writes: x0 is discarded; port 1 is dropped when port 0 targets the same register
  assign w_wr0 = bus.we0 && (bus.wa0 != '0);
  assign w_wr1 = bus.we1 && (bus.wa1 != '0) && !(w_wr0 && (bus.wa1 == bus.wa0));
  assign w_iss = bus.iss_en && (bus.iss_rd != '0);

`ifdef RF_RESET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (w_wr0) r_rf[bus.wa0] <= bus.wd0;
      if (w_wr1) r_rf[bus.wa1] <= bus.wd1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_wr0) r_rf[bus.wa0] <= bus.wd0;
      if (w_wr1) r_rf[bus.wa1] <= bus.wd1;
    end
  end
`endif

  function automatic logic [XLEN-1:0] f_read(
    input logic [AW-1:0]   addr,
    input logic            we0,
    input logic [AW-1:0]   wa0,
    input logic [XLEN-1:0] wd0,
    input logic            we1,
    input logic [AW-1:0]   wa1,
    input logic [XLEN-1:0] wd1,
    input logic [XLEN-1:0] stored
  );
    logic [XLEN-1:0] v;
    if (addr == '0)                  v = '0;
    else if (we0 && (wa0 == addr))   v = wd0;
    else if (we1 && (wa1 == addr))   v = wd1;
    else                             v = stored;
    return v;
  endfunction

  assign bus.rd1 = f_read(bus.a1, bus.we0, bus.wa0, bus.wd0, bus.we1, bus.wa1, bus.wd1, r_rf[bus.a1]);
  assign bus.rd2 = f_read(bus.a2, bus.we0, bus.wa0, bus.wd0, bus.we1, bus.wa1, bus.wd1, r_rf[bus.a2]);

  assign w_hit1    = (bus.we0 && (bus.wa0 == bus.a1))     || (bus.we1 && (bus.wa1 == bus.a1));
  assign w_hit2    = (bus.we0 && (bus.wa0 == bus.a2))     || (bus.we1 && (bus.wa1 == bus.a2));
  assign w_hit_iss = (bus.we0 && (bus.wa0 == bus.iss_rd)) || (bus.we1 && (bus.wa1 == bus.iss_rd));

  assign bus.rdy1    = (bus.a1 == '0) || !r_busy[bus.a1] || w_hit1;
  assign bus.rdy2    = (bus.a2 == '0) || !r_busy[bus.a2] || w_hit2;
  assign bus.iss_waw = w_iss && r_busy[bus.iss_rd] && !w_hit_iss;

  // Issue sets after writeback clears, so a younger producer keeps the register busy
  always_comb begin
    w_busy_next = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      w_busy_next[r] = (w_iss && (bus.iss_rd == AW'(r))) ||
                       (r_busy[r] && !((w_wr0 && (bus.wa0 == AW'(r))) ||
                                       (w_wr1 && (bus.wa1 == AW'(r)))));
    end
  end

  // Count transitions only: a set on a busy register or a clear on an idle one is a no-op
  assign w_inc  = w_iss && !r_busy[bus.iss_rd];
  assign w_dec0 = w_wr0 && r_busy[bus.wa0] && !(w_iss && (bus.iss_rd == bus.wa0));
  assign w_dec1 = w_wr1 && r_busy[bus.wa1] && !(w_iss && (bus.iss_rd == bus.wa1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= r_busy_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec0) - (AW+1)'(w_dec1);
    end
  end

  assign bus.busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, reset corner case, randomized model run.
module tb_regfile_sb;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]  a1, a2;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        chk_rd1;
    logic [31:0] e_rd1;
    logic        chk_rd2;
    logic [31:0] e_rd2;
    logic        e_rdy1, e_rdy2, e_waw;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t tbl[17];

  logic [31:0] m_rf    [NREGS];
  bit          m_known [NREGS];
  bit          m_busy  [NREGS];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t mk(int a1, int a2, int we0, int wa0, logic [31:0] wd0,
                              int we1, int wa1, logic [31:0] wd1, int ie, int ir,
                              int c1, logic [31:0] e1, int c2, logic [31:0] e2,
                              int r1, int r2, int waw, int cnt);
    vec_t v;
    v.a1 = 5'(a1); v.a2 = 5'(a2);
    v.we0 = 1'(we0); v.wa0 = 5'(wa0); v.wd0 = wd0;
    v.we1 = 1'(we1); v.wa1 = 5'(wa1); v.wd1 = wd1;
    v.iss_en = 1'(ie); v.iss_rd = 5'(ir);
    v.chk_rd1 = 1'(c1); v.e_rd1 = e1; v.chk_rd2 = 1'(c2); v.e_rd2 = e2;
    v.e_rdy1 = 1'(r1); v.e_rdy2 = 1'(r2); v.e_waw = 1'(waw); v.e_cnt = 6'(cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int a1, input int a2, input int we0, input int wa0, input logic [31:0] wd0,
                       input int we1, input int wa1, input logic [31:0] wd1, input int ie, input int ir);
    bus.a1 = 5'(a1); bus.a2 = 5'(a2);
    bus.we0 = 1'(we0); bus.wa0 = 5'(wa0); bus.wd0 = wd0;
    bus.we1 = 1'(we1); bus.wa1 = 5'(wa1); bus.wd1 = wd1;
    bus.iss_en = 1'(ie); bus.iss_rd = 5'(ir);
  endtask

  task automatic m_reset();
    for (int i = 0; i < int'(NREGS); i++) begin
      m_busy[i] = 1'b0;
`ifdef RF_RESET_EN
      m_rf[i] = '0;
      m_known[i] = 1'b1;
`endif
    end
  endtask

  function automatic bit writing(input logic [4:0] a);
    return (bus.we0 && bus.wa0 == a) || (bus.we1 && bus.wa1 == a);
  endfunction

  function automatic bit rd_known(input logic [4:0] a);
    return (a == 0) || writing(a) || m_known[a];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return '0;
    if (bus.we0 && bus.wa0 == a) return bus.wd0;
    if (bus.we1 && bus.wa1 == a) return bus.wd1;
    return m_rf[a];
  endfunction

  function automatic int m_pop();
    int c = 0;
    for (int i = 0; i < int'(NREGS); i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic check_model();
    if (rd_known(bus.a1)) chk("rand.rd1", bus.rd1, exp_rd(bus.a1));
    if (rd_known(bus.a2)) chk("rand.rd2", bus.rd2, exp_rd(bus.a2));
    chk("rand.rdy1", bus.rdy1, (bus.a1 == 0) || !m_busy[bus.a1] || writing(bus.a1));
    chk("rand.rdy2", bus.rdy2, (bus.a2 == 0) || !m_busy[bus.a2] || writing(bus.a2));
    chk("rand.iss_waw", bus.iss_waw,
        bus.iss_en && bus.iss_rd != 0 && m_busy[bus.iss_rd] && !writing(bus.iss_rd));
    chk("rand.busy_cnt", bus.busy_cnt, m_pop());
  endtask

  // Called right at the rising edge with the inputs that were sampled by it
  task automatic m_update();
    if (reset) begin
      m_reset();
    end else begin
      if (bus.we1 && bus.wa1 != 0) begin m_rf[bus.wa1] = bus.wd1; m_known[bus.wa1] = 1'b1; end
      if (bus.we0 && bus.wa0 != 0) begin m_rf[bus.wa0] = bus.wd0; m_known[bus.wa0] = 1'b1; end
      if (bus.we0) m_busy[bus.wa0] = 1'b0;
      if (bus.we1) m_busy[bus.wa1] = 1'b0;
      if (bus.iss_en && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
      m_busy[0] = 1'b0;
    end
  endtask

  task automatic cycle_model();
    @(negedge clk);
    check_model();
    @(posedge clk);
    m_update();
    #1;
  endtask

  initial begin
    tbl[0]  = mk(5,0, 0,0,0,           0,0,0,     0,0, 0,0,           1,0,     1,1,0,0);
    tbl[1]  = mk(7,0, 0,0,0,           0,0,0,     1,7, 0,0,           1,0,     1,1,0,0);
    tbl[2]  = mk(7,0, 0,0,0,           0,0,0,     0,0, 0,0,           1,0,     0,1,0,1);
    tbl[3]  = mk(7,0, 1,7,32'hDEADBEEF,0,0,0,     0,0, 1,32'hDEADBEEF,1,0,     1,1,0,1);
    tbl[4]  = mk(7,0, 0,0,0,           0,0,0,     0,0, 1,32'hDEADBEEF,1,0,     1,1,0,0);
    tbl[5]  = mk(3,0, 1,3,32'h11,      1,3,32'h22,0,0, 1,32'h11,      1,0,     1,1,0,0);
    tbl[6]  = mk(3,0, 0,0,0,           0,0,0,     0,0, 1,32'h11,      1,0,     1,1,0,0);
    tbl[7]  = mk(9,0, 0,0,0,           0,0,0,     1,9, 0,0,           1,0,     1,1,0,0);
    tbl[8]  = mk(9,0, 0,0,0,           1,9,32'h99,1,9, 1,32'h99,      1,0,     1,1,0,1);
    tbl[9]  = mk(9,0, 0,0,0,           0,0,0,     0,0, 1,32'h99,      1,0,     0,1,0,1);
    tbl[10] = mk(9,0, 0,0,0,           1,9,32'h9A,0,0, 1,32'h9A,      1,0,     1,1,0,1);
    tbl[11] = mk(9,0, 0,0,0,           0,0,0,     1,4, 1,32'h9A,      1,0,     1,1,0,0);
    tbl[12] = mk(4,0, 0,0,0,           0,0,0,     1,4, 0,0,           1,0,     0,1,1,1);
    tbl[13] = mk(0,4, 1,0,32'hFFFFFFFF,0,0,0,     1,0, 1,0,           0,0,     1,0,0,1);
    tbl[14] = mk(0,4, 0,0,0,           0,0,0,     0,0, 1,0,           0,0,     1,0,0,1);
    tbl[15] = mk(0,4, 1,4,32'h44,      0,0,0,     0,0, 1,0,           1,32'h44,1,1,0,1);
    tbl[16] = mk(0,4, 0,0,0,           0,0,0,     0,0, 1,0,           1,32'h44,1,1,0,0);
`ifdef RF_RESET_EN
    tbl[0].chk_rd1 = 1'b1;
    tbl[0].e_rd1   = '0;
`endif

    for (int i = 0; i < int'(NREGS); i++) begin
      m_known[i] = 1'b0;
      m_rf[i]    = '0;
    end
    reset = 1'b1;
    drive(0,0, 0,0,0, 0,0,0, 0,0);
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(int'(tbl[i].a1), int'(tbl[i].a2), int'(tbl[i].we0), int'(tbl[i].wa0), tbl[i].wd0,
            int'(tbl[i].we1), int'(tbl[i].wa1), tbl[i].wd1, int'(tbl[i].iss_en), int'(tbl[i].iss_rd));
      @(negedge clk);
      if (tbl[i].chk_rd1) chk($sformatf("v%0d.rd1", i), bus.rd1, tbl[i].e_rd1);
      if (tbl[i].chk_rd2) chk($sformatf("v%0d.rd2", i), bus.rd2, tbl[i].e_rd2);
      chk($sformatf("v%0d.rdy1", i), bus.rdy1, tbl[i].e_rdy1);
      chk($sformatf("v%0d.rdy2", i), bus.rdy2, tbl[i].e_rdy2);
      chk($sformatf("v%0d.iss_waw", i), bus.iss_waw, tbl[i].e_waw);
      chk($sformatf("v%0d.busy_cnt", i), bus.busy_cnt, tbl[i].e_cnt);
      @(posedge clk);
      m_update();
      #1;
    end

    // Reset asserted mid-cycle with x1..x3 busy and a write to x5 pending
    drive(5,0, 1,5,32'h55, 0,0,0, 0,0); cycle_model();
    drive(1,2, 0,0,0,      0,0,0, 1,1); cycle_model();
    drive(1,2, 0,0,0,      0,0,0, 1,2); cycle_model();
    drive(1,2, 0,0,0,      0,0,0, 1,3); cycle_model();
    drive(1,2, 0,0,0,      0,0,0, 0,0);
    @(negedge clk);
    chk("pre_rst.busy_cnt", bus.busy_cnt, 3);
    chk("pre_rst.rdy1", bus.rdy1, 0);
    @(posedge clk);
    m_update();
    #1;
    drive(1,2, 1,5,32'hBAD, 0,0,0, 0,0);
    #2 reset = 1'b1;
    #1;
    chk("rst_async.busy_cnt", bus.busy_cnt, 0);
    chk("rst_async.rdy1", bus.rdy1, 1);
    chk("rst_async.rdy2", bus.rdy2, 1);
    m_reset();
    @(posedge clk);
    m_update();
    @(negedge clk);
    reset = 1'b0;
    drive(5,0, 0,0,0, 0,0,0, 0,0);
    #1;
`ifdef RF_RESET_EN
    chk("rst_keep.rd1", bus.rd1, 0);
`else
    chk("rst_keep.rd1", bus.rd1, 32'h55);
`endif
    chk("rst_keep.busy_cnt", bus.busy_cnt, 0);
    @(posedge clk);
    m_update();
    #1;

    for (int r = 1; r < int'(NREGS); r++) begin
      drive(r, $urandom_range(0, NREGS-1), 1, r, $urandom, 0,0,0, 0,0);
      cycle_model();
    end

    for (int n = 0; n < 400; n++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? int'(NREGS) - 1 : 7;
      drive($urandom_range(0, hi), $urandom_range(0, hi),
            int'($urandom_range(0, 1)), $urandom_range(0, hi), $urandom,
            int'($urandom_range(0, 3) == 0), $urandom_range(0, hi), $urandom,
            int'($urandom_range(0, 2) == 0), $urandom_range(0, hi));
      cycle_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
